// File: rtl/fifo_byte_tx.sv
// Pops 32-bit words from a show-ahead FIFO and sends each one as a little-endian byte frame.
// Define FIFO_BYTE_TX_PARITY_EN to append an XOR parity byte, which then carries tx_last.
module fifo_byte_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        empty,
  input  logic [31:0] out_fifo,
  output logic        read_fifo_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [15:0] tx_word_cnt
);

`ifdef FIFO_BYTE_TX_PARITY_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] shreg;
  logic [2:0]  idx;
  logic        accept;
  logic        last_acc;

`ifdef FIFO_BYTE_TX_PARITY_EN
  logic [7:0] par;

  function automatic logic [7:0] word_parity(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs are decoded from registered state so reset clears them without waiting for a clock.
  always_comb begin
    state_nxt    = state;
    read_fifo_en = 1'b0;
    tx_valid     = 1'b0;
    tx_last      = 1'b0;
    busy         = 1'b0;
    tx_data      = 8'h00;
    accept       = 1'b0;
    last_acc     = 1'b0;
    case (state)
      IDLE: begin
        read_fifo_en = !empty && !rst;
        if (read_fifo_en) state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_last  = (idx == LAST_IDX);
        tx_data  = shreg[7:0];
`ifdef FIFO_BYTE_TX_PARITY_EN
        if (idx == LAST_IDX) tx_data = par;
`endif
        accept       = tx_ready;
        last_acc     = tx_ready && tx_last;
        read_fifo_en = last_acc && !empty && !rst;
        if (last_acc && !read_fifo_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A reload on the last accepted byte takes priority so back-to-back words have no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= 32'h0;
      idx         <= 3'd0;
      tx_word_cnt <= 16'h0;
`ifdef FIFO_BYTE_TX_PARITY_EN
      par         <= 8'h00;
`endif
    end else begin
      if (read_fifo_en) begin
        shreg <= out_fifo;
        idx   <= 3'd0;
`ifdef FIFO_BYTE_TX_PARITY_EN
        par   <= word_parity(out_fifo);
`endif
      end else if (last_acc) begin
        idx <= 3'd0;
      end else if (accept) begin
        shreg <= {8'h00, shreg[31:8]};
        idx   <= idx + 3'd1;
      end
      if (last_acc) tx_word_cnt <= tx_word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_byte_tx.sv
// Bench for fifo_byte_tx: frame-level reference model checked every cycle, plus directed literal cases.
// Honours FIFO_BYTE_TX_PARITY_EN the same way the design does.
module tb_fifo_byte_tx;

`ifdef FIFO_BYTE_TX_PARITY_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty = 1'b1;
  logic [31:0] out_fifo = 32'h0;
  logic        read_fifo_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;
  logic [15:0] tx_word_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  acc_log[$];
  logic        last_log[$];
  int          acc_cyc[$];
  int          pop_cyc[$];
  int          pop_cnt = 0;
  int          cyc = 0;
  logic        s_ren = 1'b0;

  // reference model: the frame being sent and the position within it
  logic        m_held = 1'b0;
  logic [7:0]  m_bytes[5];
  int          m_pos = 0;
  logic [15:0] m_cnt = 16'h0;

  logic [7:0]  exp_a[10];

  always #5 clk = ~clk;

  fifo_byte_tx dut (
    .clk(clk),
    .rst(rst),
    .empty(empty),
    .out_fifo(out_fifo),
    .read_fifo_en(read_fifo_en),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_last(tx_last),
    .busy(busy),
    .tx_word_cnt(tx_word_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    empty    = 1'b0;
    out_fifo = fifo_q[0];
  endtask

  task automatic clear_logs();
    acc_log.delete();
    last_log.delete();
    acc_cyc.delete();
    pop_cyc.delete();
    pop_cnt = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((fifo_q.size() != 0 || busy) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", (n >= max), 1'b0);
  endtask

  function automatic void frame_of(input logic [31:0] w, output logic [7:0] b[5]);
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
  endfunction

  // compare DUT against the model, then advance the model to what the next posedge produces
  always @(negedge clk) begin
    logic [7:0] ed;
    logic       el;
    logic       ep;
    cyc++;
    if (rst) begin
      check("rst_valid", tx_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data", tx_data, 8'h00);
      check("rst_last", tx_last, 1'b0);
      check("rst_ren", read_fifo_en, 1'b0);
      check("rst_cnt", tx_word_cnt, 16'h0);
      m_held = 1'b0;
      m_pos  = 0;
      m_cnt  = 16'h0;
      s_ren  = 1'b0;
    end else begin
      ed = m_held ? m_bytes[m_pos] : 8'h00;
      el = m_held && (m_pos == N - 1);
      ep = !empty && (!m_held || (tx_ready && m_pos == N - 1));
      check("valid", tx_valid, m_held);
      check("busy", busy, m_held);
      check("data", tx_data, ed);
      check("last", tx_last, el);
      check("ren", read_fifo_en, ep);
      check("cnt", tx_word_cnt, m_cnt);
      s_ren = read_fifo_en;
      if (tx_valid && tx_ready) begin
        acc_log.push_back(tx_data);
        last_log.push_back(tx_last);
        acc_cyc.push_back(cyc);
      end
      if (read_fifo_en) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
      if (m_held && tx_ready) begin
        if (m_pos == N - 1) begin
          m_cnt  = m_cnt + 16'd1;
          m_held = 1'b0;
        end else begin
          m_pos++;
        end
      end
      if (ep) begin
        frame_of(out_fifo, m_bytes);
        m_held = 1'b1;
        m_pos  = 0;
      end
    end
  end

  // the FIFO pops on the same edge as the DUT; flags update after the edge
  always @(posedge clk) begin
    if (!rst && s_ren && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      empty    <= (fifo_q.size() == 0);
      out_fifo <= (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    push(32'h44332211);
    #1;
    check("rst_hold_ren", read_fifo_en, 1'b0);
    check("rst_hold_data", tx_data, 8'h00);
    check("rst_hold_busy", busy, 1'b0);

    // single word straight after reset release
    @(posedge clk); #1;
    clear_logs();
    rst = 1'b0;
    tx_ready = 1'b1;
    wait_idle(50);
    exp_a[0] = 8'h11; exp_a[1] = 8'h22; exp_a[2] = 8'h33; exp_a[3] = 8'h44; exp_a[4] = 8'h44;
    check("w1_len", acc_log.size(), N);
    for (int i = 0; i < N && i < acc_log.size(); i++) begin
      check("w1_byte", acc_log[i], exp_a[i]);
      check("w1_lastflag", last_log[i], (i == N - 1));
    end
    if (acc_cyc.size() == N) check("w1_contig", acc_cyc[N-1] - acc_cyc[0], N - 1);
    check("w1_pops", pop_cnt, 1);
    check("w1_cnt", tx_word_cnt, 16'd1);
    check("w1_busy", busy, 1'b0);

    // two queued words, no bubble between frames
    clear_logs();
    push(32'hA1B2C3D4);
    push(32'h00000001);
    wait_idle(60);
`ifdef FIFO_BYTE_TX_PARITY_EN
    exp_a[0] = 8'hD4; exp_a[1] = 8'hC3; exp_a[2] = 8'hB2; exp_a[3] = 8'hA1; exp_a[4] = 8'h04;
    exp_a[5] = 8'h01; exp_a[6] = 8'h00; exp_a[7] = 8'h00; exp_a[8] = 8'h00; exp_a[9] = 8'h01;
`else
    exp_a[0] = 8'hD4; exp_a[1] = 8'hC3; exp_a[2] = 8'hB2; exp_a[3] = 8'hA1;
    exp_a[4] = 8'h01; exp_a[5] = 8'h00; exp_a[6] = 8'h00; exp_a[7] = 8'h00;
`endif
    check("w2_len", acc_log.size(), 2 * N);
    for (int i = 0; i < 2 * N && i < acc_log.size(); i++) check("w2_byte", acc_log[i], exp_a[i]);
    if (acc_cyc.size() == 2 * N) check("w2_contig", acc_cyc[2*N-1] - acc_cyc[0], 2 * N - 1);
    check("w2_pops", pop_cnt, 2);
    if (pop_cyc.size() == 2 && acc_cyc.size() >= N) check("w2_pop_at_last", pop_cyc[1], acc_cyc[N-1]);
    check("w2_cnt", tx_word_cnt, 16'd3);

    // backpressure on byte 1
    clear_logs();
    push(32'h44332211);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_data", tx_data, 8'h22);
      check("bp_valid", tx_valid, 1'b1);
      check("bp_ren", read_fifo_en, 1'b0);
      @(posedge clk); #1;
    end
    check("bp_data_after", tx_data, 8'h22);
    tx_ready = 1'b1;
    wait_idle(50);
    check("bp_len", acc_log.size(), N);
    if (acc_log.size() >= 3) check("bp_byte2", acc_log[2], 8'h33);
    check("bp_pops", pop_cnt, 1);

    // reset mid-frame after byte 0x22 accepted
    clear_logs();
    push(32'h44332211);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", tx_valid, 1'b0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cnt", tx_word_cnt, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_bytes", acc_log.size(), 2);
    check("mid_rst_pops", pop_cnt, 1);
    check("mid_rst_cnt_after", tx_word_cnt, 16'h0);

    // randomized traffic, backpressure and occasional reset
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) push($urandom);
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    tx_ready = 1'b1;
    wait_idle(100);

    // counter wrap from a preset value
    force dut.tx_word_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    @(posedge clk); #2;
    release dut.tx_word_cnt;
    #1;
    check("wrap_preset", tx_word_cnt, 16'hFFFE);
    push($urandom);
    push($urandom);
    wait_idle(60);
    check("wrap_cnt", tx_word_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
